// File: rtl/shift_unit.sv
// Multi-bit shift/rotate unit: loads a zero-extended operand, then performs a
// shift-by-N one bit per clock with a start/busy/done handshake.
module shift_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH   = 4,
  parameter int AMT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   in,
  input  logic                  loadEnable,
  input  logic                  start,
  input  logic [2:0]            mode,
  input  logic [AMT_WIDTH-1:0]  amount,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  flag,
  output logic                  zero,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [2:0]           mode_q;
  logic [AMT_WIDTH-1:0] cnt;

  function automatic logic is_shift(input logic [2:0] m);
    return (m >= 3'd1) && (m <= 3'd5);
  endfunction

  // One 1-bit step; returns {flag, out}. Hold and reserved codes keep both.
  function automatic logic [DATA_WIDTH:0] step(input logic [2:0] m,
                                               input logic [DATA_WIDTH-1:0] v,
                                               input logic f);
    logic [DATA_WIDTH:0] r;
    r = {f, v};
    case (m)
      3'b001:  r = {v[DATA_WIDTH-1], v[DATA_WIDTH-2:0], 1'b0};
      3'b010:  r = {v[0], 1'b0, v[DATA_WIDTH-1:1]};
      3'b011:  r = {v[0], v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
      3'b100:  r = {v[DATA_WIDTH-1], v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
      3'b101:  r = {v[0], v[0], v[DATA_WIDTH-1:1]};
      default: r = {f, v};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      out    <= '0;
      flag   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      mode_q <= 3'b000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (loadEnable) begin
            out  <= DATA_WIDTH'(in);
            flag <= 1'b0;
          end else if (start) begin
            mode_q <= mode;
            if (amount == '0 || !is_shift(mode)) begin
              done <= 1'b1;
            end else begin
              // The accepting edge already performs the first step.
              {flag, out} <= step(mode, out, flag);
              cnt         <= amount - AMT_WIDTH'(1);
              if (amount != AMT_WIDTH'(1)) begin
                state <= SHIFT;
                busy  <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
        end
        SHIFT: begin
          {flag, out} <= step(mode_q, out, flag);
          cnt         <= cnt - AMT_WIDTH'(1);
          if (cnt == AMT_WIDTH'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign zero = (out == '0);

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed scenarios plus randomized
// operations compared against a whole-shift arithmetic reference model.
module tb_shift_unit;

  logic       clk;
  logic       reset;
  logic [3:0] dataIn;
  logic       loadEnable;
  logic       start;
  logic [2:0] mode;
  logic [2:0] amount;
  logic [7:0] out;
  logic       flag;
  logic       zero;
  logic       busy;
  logic       done;

  int         checkCount = 0;
  int         passCount  = 0;
  logic [7:0] modelOut;
  logic       modelFlag;

  shift_unit #(.DATA_WIDTH(8), .IN_WIDTH(4), .AMT_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .in(dataIn), .loadEnable(loadEnable),
    .start(start), .mode(mode), .amount(amount), .out(out), .flag(flag),
    .zero(zero), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Result of shifting v by a whole amount a at once; returns {flag, value}.
  function automatic logic [8:0] refShift(input logic [7:0] v, input logic f,
                                          input logic [2:0] m, input int a);
    logic [15:0] w;
    logic [7:0]  r;
    logic        nf;
    if (a == 0 || m == 3'd0 || m > 3'd5) return {f, v};
    r  = v;
    nf = f;
    case (m)
      3'd1: begin w = {8'h00, v} << a; r = w[7:0]; nf = w[8]; end
      3'd2: begin r = v >> a; nf = v[a-1]; end
      3'd3: begin r = $signed(v) >>> a; nf = v[a-1]; end
      3'd4: begin w = {v, v} << a; r = w[15:8]; nf = r[0]; end
      3'd5: begin w = {v, v} >> a; r = w[7:0]; nf = r[7]; end
      default: ;
    endcase
    return {nf, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  task automatic checkAll(input string tag, input logic expBusy, input logic expDone);
    checkOutput({tag, "_out"},  32'(out),  32'(modelOut));
    checkOutput({tag, "_flag"}, 32'(flag), 32'(modelFlag));
    checkOutput({tag, "_zero"}, 32'(zero), 32'(modelOut == 8'h00));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(expBusy));
    checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
  endtask

  task automatic applyStimulus(input logic le, input logic st, input logic [3:0] d,
                               input logic [2:0] m, input logic [2:0] a);
    loadEnable = le;
    start      = st;
    dataIn     = d;
    mode       = m;
    amount     = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic loadValue(input logic [3:0] v, input logic alsoStart);
    applyStimulus(1'b1, alsoStart, v, 3'($urandom), 3'($urandom_range(1, 7)));
    modelOut  = {4'h0, v};
    modelFlag = 1'b0;
    checkAll("load", 1'b0, 1'b0);
    if (alsoStart) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 3'd0);
      checkAll("load_nostart", 1'b0, 1'b0);
    end
  endtask

  // noise: 0 idle inputs while busy, 1 random inputs, 2 load+LSR request
  task automatic runShift(input logic [2:0] m, input int a, input int noise);
    logic [7:0] origOut;
    logic       origFlag;
    logic [8:0] r;
    origOut  = modelOut;
    origFlag = modelFlag;
    applyStimulus(1'b0, 1'b1, 4'($urandom), m, 3'(a));
    if (a == 0 || m == 3'd0 || m > 3'd5) begin
      checkAll("noop", 1'b0, 1'b1);
    end else begin
      for (int i = 1; i <= a; i++) begin
        r         = refShift(origOut, origFlag, m, i);
        modelOut  = r[7:0];
        modelFlag = r[8];
        checkAll("step", i < a, i == a);
        if (i < a) begin
          if (noise == 1) begin
            loadEnable = 1'($urandom);
            start      = 1'($urandom);
            dataIn     = 4'($urandom);
            mode       = 3'($urandom);
            amount     = 3'($urandom);
          end else if (noise == 2) begin
            loadEnable = 1'b1;
            start      = 1'b1;
            dataIn     = 4'h3;
            mode       = 3'b010;
          end else begin
            loadEnable = 1'b0;
            start      = 1'b0;
          end
          @(posedge clk);
          @(negedge clk);
        end
      end
    end
    loadEnable = 1'b0;
    start      = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    loadEnable = 1'b0;
    start      = 1'b1;
    mode       = 3'b001;
    amount     = 3'd3;
    dataIn     = 4'h0;
    modelOut   = 8'h00;
    modelFlag  = 1'b0;

    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checkAll("reset", 1'b0, 1'b0);
    end
    reset = 1'b1;
    start = 1'b0;

    loadValue(4'hB, 1'b0);
    checkOutput("load_B", 32'(out), 32'h0B);
    runShift(3'd1, 4, 0);
    checkOutput("lsl4_B", 32'(out), 32'hB0);

    loadValue(4'h9, 1'b0);
    runShift(3'd1, 4, 0);
    checkOutput("lsl4_9", 32'(out), 32'h90);
    runShift(3'd3, 2, 0);
    checkOutput("asr2", 32'(out), 32'hE4);
    checkOutput("asr2_flag", 32'(flag), 32'h0);
    runShift(3'd2, 3, 0);
    checkOutput("lsr3", 32'(out), 32'h1C);
    checkOutput("lsr3_flag", 32'(flag), 32'h1);

    runShift(3'd2, 0, 0);
    runShift(3'd6, 5, 0);
    runShift(3'd0, 3, 0);
    runShift(3'd7, 2, 1);
    checkOutput("noop_keep", 32'({flag, out}), 32'h11C);

    loadValue(4'h1, 1'b0);
    runShift(3'd5, 1, 0);
    checkOutput("ror1", 32'({flag, out}), 32'h180);
    runShift(3'd4, 7, 0);
    checkOutput("rol7", 32'({flag, out}), 32'h040);

    loadValue(4'h7, 1'b1);
    runShift(3'd1, 5, 2);
    runShift(3'd5, 3, 1);

    loadValue(4'hF, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h0, 3'd1, 3'd7);
    modelOut = 8'h1E;
    checkAll("abort_first", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 3'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 3'd0);
    modelOut  = 8'h00;
    modelFlag = 1'b0;
    checkAll("abort", 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 3'd0);
    checkAll("abort_after", 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        loadValue(4'($urandom), 1'($urandom));
      else
        runShift(3'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
